uart_rx_core: RTL and testbench
===============================

# uart_rx_core

UART receiver core for the DE0-Nano UART path: deserialises 8-bit LSB-first frames from `uart_rx` into a small receive FIFO, exposes bytes on a valid/ready interface, and drives `uart_cts` for hardware flow control toward the host. It sits between the board pin and the command parser. It is also the counterpart to the bench serial driver, which transmits 10-bit start/data/stop frames at 115200 baud.

## Interface
- `CLK_HZ`, 50000000: system clock frequency.
- `BAUD`, 115200: line rate. The bit period is `DIV = (CLK_HZ + BAUD/2) / BAUD`, which gives 434 at the defaults. Half-bit is `HALF = DIV/2`, which gives 217.
- `FIFO_DEPTH`, 16: receive FIFO depth. Must be a power of 2 and at least 8.
- `clk` input 1: system clock. All logic runs on its rising edge.
- `rsth` input 1: reset, synchronous, active-high.
- `uart_rx` input 1: serial line. Asynchronous to `clk`; idle level is high.
- `uart_cts` output 1: flow control. 0 permits the host to send; 1 asks the host to pause.
- `rx_data` output 8: head-of-FIFO byte.
- `rx_valid` output 1: `rx_data` holds a valid byte.
- `rx_ready` input 1: consumer accepts the byte.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_err` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `parity_err` output 1: one-cycle pulse on a parity mismatch. Constant 0 when parity is compiled out.

## Operation
- **Input synchroniser.** `uart_rx` passes through a 2-FF synchroniser; both flops reset to 1. Falling-edge detect is done on the synchronised signal.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
- **IDLE.** On a falling edge, load the baud counter with HALF and go to START.
- **START.** When the counter expires, sample the line:
  - Line is 0: reload DIV, clear the bit index, go to DATA.
  - Line is 1: treat as a glitch and return to IDLE. Nothing is written and no error is flagged.
- **DATA.** Sample once per DIV expiry and shift in LSB first.
  - After bit index 7, go to PARITY if compiled in, otherwise to STOP.
- **STOP.** Sample at DIV expiry:
  - Line is 1, FIFO not full: write the byte and go to IDLE.
  - Line is 1, FIFO full: drop the byte, pulse `overrun_err`, go to IDLE.
  - Line is 0: discard the byte, pulse `frame_err`, go to BREAK.
- **BREAK.** Wait until the synchronised line is 1, then go to IDLE. This prevents a false start during a held-low break.
- **FIFO.** Show-ahead: `rx_data` is valid whenever `rx_valid` is 1. A pop happens on `rx_valid && rx_ready`.
  - Simultaneous push and pop when full: the pop frees a slot first, so the push succeeds and there is no overrun.
- **Flow control on `uart_cts`:**
  - Set to 1 when the fill level is at or above `FIFO_DEPTH-4`. This leaves 4 bytes of headroom for the byte in flight plus host latency.
  - Cleared to 0 when the level is at or below `FIFO_DEPTH/2`.
  - Between those thresholds it holds its previous value (hysteresis).
- **Reset mid-frame.** The frame is abandoned, the FSM goes to IDLE, the FIFO is emptied and the error pulses are cleared.

## Timing
- Reset values: `uart_cts` = 1, `rx_valid` = 0, `rx_data` = 0x00, `frame_err` = `overrun_err` = `parity_err` = 0.
- `uart_cts` falls to 0 on the first clock after `rsth` deasserts.
- Input latency: 2 cycles through the synchroniser. Each sample point is nominally mid-bit.
- Stop-bit sample at cycle S:
  - FIFO write at S+1.
  - `rx_valid` high at S+2 when the FIFO was empty.
  - Error pulses are high during S+1 only.
- Pop at cycle P: the next entry appears on `rx_data` at P+1, and `rx_valid` falls at P+1 if the FIFO empties.
- `uart_cts` is registered and updates one cycle after the level crosses a threshold.
- Back-to-back frames: a new start edge is accepted the cycle after STOP returns to IDLE. This gives about half a bit of slack before the next start bit.

## Configuration
- `UART_RX_PARITY_EN` defined: the frame has an even parity bit after data bit 7.
  - The PARITY state samples it at DIV.
  - On mismatch, pulse `parity_err` at S+1 and discard the byte. The stop bit is still checked.
- `UART_RX_PARITY_EN` undefined: 8N1 framing, no PARITY state, `parity_err` tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the FSM state enum `uart_rx_state_t`;
  - the divisor function `uart_div(clk_hz, baud)`;
  - the constant `UART_DATA_W = 8`;
  - the constants `UART_CTS_READY = 1'b0` and `UART_CTS_STOP = 1'b1`.
- Sub-module `uart_sync_fifo`:
  - parameters `WIDTH` and `DEPTH`;
  - show-ahead output;
  - ports for `full`, `empty` and a `level` output with `$clog2(DEPTH)+1` bits.
- The FSM, baud counter, shifter, synchroniser and CTS hysteresis stay in `uart_rx_core`.

## Test plan
- Send 0x45 ('E') as 8N1 at 115200 with `rx_ready` = 1. Required: one `rx_valid` cycle with `rx_data` = 0x45, 2 cycles after the stop-bit sample.
- Drive a 1 µs low glitch on an idle line. Required: no FIFO write and no error pulse; FSM returns to IDLE about 217 cycles after the edge.
- Send 0x41 with the stop bit forced to 0, hold the line low for 2 bit times, then send 0x42. Required: one `frame_err` pulse, no 0x41 in the FIFO, 0x42 received correctly.
- With `rx_ready` = 0, send 17 bytes 0x00–0x10. Required:
  - `uart_cts` goes to 1 after the 12th write;
  - the 17th byte gives one `overrun_err` pulse;
  - after popping to level 8, `uart_cts` returns to 0;
  - the 16 stored bytes read out as 0x00–0x0F.
- Send the 16-byte string "ECHO ABCDE\nYZ QA" back-to-back, then assert `rsth` for 1 cycle midway through a 17th frame. Required:
  - all 16 bytes read in order;
  - after reset, `rx_valid` = 0 and `uart_cts` = 1, then 0;
  - the partial frame produces no write.
- With `UART_RX_PARITY_EN` defined, send 0x07 with parity bit 0. Required: `parity_err` pulse and the byte discarded. With parity bit 1, 0x07 is received.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   uart_rx_state_t : receiver FSM state encoding
//   uart_div()      : rounded clocks-per-bit divisor
//   UART_DATA_W     : data bits per frame
//   UART_CTS_*      : flow-control line levels toward the host
package uart_pkg;

  localparam int unsigned UART_DATA_W = 8;

  // CTS is active-low toward the host: 0 lets it send, 1 asks it to pause.
  localparam logic UART_CTS_READY = 1'b0;
  localparam logic UART_CTS_STOP  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_rx_state_t;

  // Rounded to the nearest clock so the bit period error stays below half a clock.
  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock show-ahead FIFO.
//   clk, rsth     : clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   : write request and data
//   pop           : read request; ignored when empty
//   rdata         : head entry, valid whenever empty is 0 (reads 0 when empty)
//   full, empty   : occupancy flags
//   level         : current number of entries
// A push while full is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rsth,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FullLvl);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign pop_ok  = pop && !empty;
  // The pop frees its slot first, so a push into a full FIFO survives a same-cycle pop.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rsth) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver with receive FIFO and CTS flow control.
//   clk          : system clock, all logic on the rising edge
//   rsth         : synchronous active-high reset
//   uart_rx      : asynchronous serial input, idle high
//   uart_cts     : flow control toward host (0 = send, 1 = pause)
//   rx_data      : head-of-FIFO byte (0 when empty)
//   rx_valid     : rx_data holds a byte; popped on rx_valid && rx_ready
//   rx_ready     : consumer accepts the head byte
//   frame_err    : one-cycle pulse, stop bit sampled low
//   overrun_err  : one-cycle pulse, good byte dropped on a full FIFO
//   parity_err   : one-cycle pulse on even-parity mismatch
// Build option: define UART_RX_PARITY_EN for 8E1 framing; otherwise 8N1 and parity_err is 0.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rsth,
  input  logic                   uart_rx,
  output logic                   uart_cts,
  output logic [UART_DATA_W-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   parity_err
);

  localparam int unsigned DIV  = uart_div(CLK_HZ, BAUD);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CntW = $clog2(DIV);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  // Counter counts down to zero, so a load of N-1 expires after N clocks.
  localparam logic [CntW-1:0] CntHalf = CntW'(HALF - 1);
  localparam logic [CntW-1:0] CntBit  = CntW'(DIV - 1);

  // Pause threshold leaves four slots for the byte in flight plus host reaction time.
  localparam logic [LvlW-1:0] CtsHiLvl = LvlW'(FIFO_DEPTH - 4);
  localparam logic [LvlW-1:0] CtsLoLvl = LvlW'(FIFO_DEPTH / 2);

  // Input synchroniser and edge detect
  logic [1:0] sync_q;
  logic       rx_prev_q;
  logic       rx_s;
  logic       rx_fall;

  assign rx_s    = sync_q[1];
  assign rx_fall = rx_prev_q && !rx_s;

  // Receiver state
  uart_rx_state_t         state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   push_q, push_d;
  logic                   ferr_q, ferr_d;
  logic                   cnt_expire;
  logic                   par_bad;

  // FIFO and flow control
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [LvlW-1:0] fifo_level;
  logic            cts_q, cts_d;

  assign cnt_expire = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
  assign par_bad    = par_bad_q;
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_expire ? cnt_q : cnt_q - 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_d    = 1'b0;
    ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (rx_fall) begin
          cnt_d   = CntHalf;
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_expire) begin
          if (!rx_s) begin
            cnt_d     = CntBit;
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            state_d   = StData;
          end else begin
            // Line back high at mid start bit: a glitch, not a frame.
            state_d = StIdle;
          end
        end
      end

      StData: begin
        if (cnt_expire) begin
          shift_d   = {rx_s, shift_q[UART_DATA_W-1:1]};
          cnt_d     = CntBit;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_expire) begin
          // Even parity: data plus parity bit must hold an even number of ones.
          par_bad_d = (^shift_q) ^ rx_s;
          cnt_d     = CntBit;
          state_d   = StStop;
        end
      end
`endif

      StStop: begin
        if (cnt_expire) begin
`ifdef UART_RX_PARITY_EN
          perr_d = par_bad;
`endif
          if (rx_s) begin
            push_d  = !par_bad;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end
      end

      StBreak: begin
        // Hold off until the line returns high so a long break cannot look like a start bit.
        if (rx_s) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsth) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      cts_q     <= UART_CTS_STOP;
    end else begin
      sync_q    <= {sync_q[0], uart_rx};
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      ferr_q    <= ferr_d;
      cts_q     <= cts_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rsth) begin
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
    end
  end
`endif

  // Hysteresis: pause at the high threshold, resume only once drained to half full.
  always_comb begin
    cts_d = cts_q;
    if (fifo_level >= CtsHiLvl) begin
      cts_d = UART_CTS_STOP;
    end else if (fifo_level <= CtsLoLvl) begin
      cts_d = UART_CTS_READY;
    end
  end

  assign fifo_pop    = rx_valid && rx_ready;
  assign rx_valid    = !fifo_empty;
  assign uart_cts    = cts_q;
  assign frame_err   = ferr_q;
  // shift_q is stable while push_q is high, the next frame cannot shift until mid start bit.
  assign overrun_err = push_q && fifo_full && !fifo_pop;

  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rsth  (rsth),
    .push  (push_q),
    .wdata (shift_q),
    .pop   (fifo_pop),
    .rdata (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core.
// The DUT runs at 40 clocks per bit (CLK_HZ = 40 * 115200) to keep the run short;
// HALF = 20, so the glitch, break and mid-frame timings are scaled to match.
module tb_uart_rx_core;

  localparam int ClkHz = 4608000;
  localparam int Baud  = 115200;
  localparam int Div   = 40;
  localparam int Half  = 20;
  localparam int Depth = 16;
  // Start-edge to rx_valid: 2 sync + 1 edge reg + HALF + 9*DIV (+DIV parity) + write + show.
`ifdef UART_RX_PARITY_EN
  localparam int RxLatency = 424;
`else
  localparam int RxLatency = 384;
`endif

  logic       clk      = 1'b0;
  logic       rsth     = 1'b1;
  logic       uart_rx  = 1'b1;
  logic       rx_ready = 1'b0;
  logic       uart_cts;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  int         cyc       = 0;
  int         n_ferr    = 0;
  int         n_ovr     = 0;
  int         n_perr    = 0;
  int         n_vcyc    = 0;
  int         cap_n     = 0;
  int         rise_cyc  = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] cap_mem [256];
  int         start_cyc = 0;
  logic       par_flip  = 1'b0;

  uart_rx_core #(
    .CLK_HZ     (ClkHz),
    .BAUD       (Baud),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk         (clk),
    .rsth        (rsth),
    .uart_rx     (uart_rx),
    .uart_cts    (uart_cts),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (frame_err)   n_ferr <= n_ferr + 1;
    if (overrun_err) n_ovr  <= n_ovr + 1;
    if (parity_err)  n_perr <= n_perr + 1;
    if (rx_valid)    n_vcyc <= n_vcyc + 1;
    if (rx_valid && rx_ready) begin
      cap_mem[cap_n[7:0]] <= rx_data;
      cap_n <= cap_n + 1;
    end
    if (rx_valid && !valid_prev) rise_cyc <= cyc;
    valid_prev <= rx_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    start_cyc = cyc;
    uart_rx = 1'b0;
    tick(Div);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(Div);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = (^d) ^ par_flip;
    tick(Div);
`endif
    uart_rx = stop_bit;
    tick(Div);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick(5);
    if (uart_cts !== 1'b1) begin
      $display("FAIL reset_cts: got %b expected 1", uart_cts); errors++;
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL reset_valid: got %b expected 0", rx_valid); errors++;
    end
    checks++;
    if (rx_data !== 8'h00) begin
      $display("FAIL reset_data: got %h expected 00", rx_data); errors++;
    end
    checks++;
    if ({frame_err, overrun_err, parity_err} !== 3'b000) begin
      $display("FAIL reset_errs: got %b expected 000", {frame_err, overrun_err, parity_err});
      errors++;
    end
    checks++;
    rsth = 1'b0;
    if (uart_cts !== 1'b1) begin
      $display("FAIL reset_cts_hold: got %b expected 1", uart_cts); errors++;
    end
    checks++;
    tick(1);
    if (uart_cts !== 1'b0) begin
      $display("FAIL reset_cts_fall: got %b expected 0", uart_cts); errors++;
    end
    checks++;
  endtask

  task automatic test_single_byte();
    int c0, v0, f0, o0;
    c0 = cap_n; v0 = n_vcyc; f0 = n_ferr; o0 = n_ovr;
    rx_ready = 1'b1;
    tick(Div);
    send_frame(8'h45, 1'b1);
    tick(Div);
    if (cap_n - c0 !== 1) begin
      $display("FAIL single_count: got %0d expected 1", cap_n - c0); errors++;
    end
    checks++;
    if (cap_mem[c0] !== 8'h45) begin
      $display("FAIL single_data: got %h expected 45", cap_mem[c0]); errors++;
    end
    checks++;
    if (rise_cyc - start_cyc !== RxLatency) begin
      $display("FAIL single_latency: got %0d expected %0d", rise_cyc - start_cyc, RxLatency);
      errors++;
    end
    checks++;
    if (n_vcyc - v0 !== 1) begin
      $display("FAIL single_valid_cycles: got %0d expected 1", n_vcyc - v0); errors++;
    end
    checks++;
    if ((n_ferr - f0) + (n_ovr - o0) !== 0) begin
      $display("FAIL single_errs: got %0d expected 0", (n_ferr - f0) + (n_ovr - o0)); errors++;
    end
    checks++;
  endtask

  task automatic test_glitch();
    int c0, f0, o0;
    c0 = cap_n; f0 = n_ferr; o0 = n_ovr;
    uart_rx = 1'b0;
    tick(5);
    uart_rx = 1'b1;
    // FSM should be idle again about HALF+3 clocks after the edge; restart at +27.
    tick(22);
    if (cap_n - c0 !== 0 || rx_valid !== 1'b0) begin
      $display("FAIL glitch_write: got count %0d valid %b expected 0 0", cap_n - c0, rx_valid);
      errors++;
    end
    checks++;
    send_frame(8'h5A, 1'b1);
    tick(Div);
    if (cap_n - c0 !== 1 || cap_mem[c0] !== 8'h5A) begin
      $display("FAIL glitch_recover: got count %0d data %h expected 1 5a", cap_n - c0,
               cap_mem[c0]);
      errors++;
    end
    checks++;
    if ((n_ferr - f0) + (n_ovr - o0) !== 0) begin
      $display("FAIL glitch_errs: got %0d expected 0", (n_ferr - f0) + (n_ovr - o0)); errors++;
    end
    checks++;
  endtask

  task automatic test_frame_err();
    int c0, f0;
    c0 = cap_n; f0 = n_ferr;
    send_frame(8'h41, 1'b0);
    tick(2 * Div);
    uart_rx = 1'b1;
    tick(Div);
    send_frame(8'h42, 1'b1);
    tick(Div);
    if (n_ferr - f0 !== 1) begin
      $display("FAIL frame_err_pulses: got %0d expected 1", n_ferr - f0); errors++;
    end
    checks++;
    if (cap_n - c0 !== 1) begin
      $display("FAIL frame_err_count: got %0d expected 1", cap_n - c0); errors++;
    end
    checks++;
    if (cap_mem[c0] !== 8'h42) begin
      $display("FAIL frame_err_next: got %h expected 42", cap_mem[c0]); errors++;
    end
    checks++;
  endtask

  task automatic test_overrun();
    int o0;
    o0 = n_ovr;
    rx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1);
      if (i == 10) begin
        if (uart_cts !== 1'b0) begin
          $display("FAIL cts_at_11: got %b expected 0", uart_cts); errors++;
        end
        checks++;
      end
      if (i == 11) begin
        if (uart_cts !== 1'b1) begin
          $display("FAIL cts_at_12: got %b expected 1", uart_cts); errors++;
        end
        checks++;
      end
      if (i == 15) begin
        if (n_ovr - o0 !== 0) begin
          $display("FAIL overrun_early: got %0d expected 0", n_ovr - o0); errors++;
        end
        checks++;
      end
    end
    tick(Div);
    if (n_ovr - o0 !== 1) begin
      $display("FAIL overrun_pulses: got %0d expected 1", n_ovr - o0); errors++;
    end
    checks++;
    for (int j = 0; j < 16; j++) begin
      if (rx_valid !== 1'b1 || rx_data !== 8'(j)) begin
        $display("FAIL drain_%0d: got valid %b data %h expected 1 %h", j, rx_valid, rx_data,
                 8'(j));
        errors++;
      end
      checks++;
      pop_one();
      if (j == 6) begin
        tick(2);
        if (uart_cts !== 1'b1) begin
          $display("FAIL cts_at_9: got %b expected 1", uart_cts); errors++;
        end
        checks++;
      end
      if (j == 7) begin
        if (uart_cts !== 1'b1) begin
          $display("FAIL cts_at_8_same: got %b expected 1", uart_cts); errors++;
        end
        checks++;
        tick(1);
        if (uart_cts !== 1'b0) begin
          $display("FAIL cts_at_8: got %b expected 0", uart_cts); errors++;
        end
        checks++;
      end
    end
    if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      $display("FAIL drain_empty: got valid %b data %h expected 0 00", rx_valid, rx_data);
      errors++;
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    string msg;
    int c0, c1, f0;
    msg = "ECHO ABCDE\nYZ QA";
    c0 = cap_n; f0 = n_ferr;
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) send_frame(msg[i], 1'b1);
    // Partial 0xFF frame: start bit, then reset in the middle of data bit 4.
    uart_rx = 1'b0;
    tick(Div);
    uart_rx = 1'b1;
    tick(4 * Div + Div / 2);
    c1 = cap_n;
    rsth = 1'b1;
    tick(1);
    rsth = 1'b0;
    if (rx_valid !== 1'b0 || uart_cts !== 1'b1) begin
      $display("FAIL midreset_state: got valid %b cts %b expected 0 1", rx_valid, uart_cts);
      errors++;
    end
    checks++;
    tick(1);
    if (uart_cts !== 1'b0) begin
      $display("FAIL midreset_cts: got %b expected 0", uart_cts); errors++;
    end
    checks++;
    tick(6 * Div);
    if (cap_n !== c1 || rx_valid !== 1'b0) begin
      $display("FAIL midreset_write: got %0d extra valid %b expected 0 0", cap_n - c1,
               rx_valid);
      errors++;
    end
    checks++;
    if (c1 - c0 !== 16) begin
      $display("FAIL b2b_count: got %0d expected 16", c1 - c0); errors++;
    end
    checks++;
    for (int i = 0; i < 16; i++) begin
      if (cap_mem[c0 + i] !== msg[i]) begin
        $display("FAIL b2b_byte_%0d: got %h expected %h", i, cap_mem[c0 + i], msg[i]);
        errors++;
      end
      checks++;
    end
    if (n_ferr - f0 !== 0) begin
      $display("FAIL b2b_frame_err: got %0d expected 0", n_ferr - f0); errors++;
    end
    checks++;
  endtask

  task automatic test_parity();
`ifdef UART_RX_PARITY_EN
    int c0, p0;
    c0 = cap_n; p0 = n_perr;
    rx_ready = 1'b1;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tick(Div);
    par_flip = 1'b0;
    if (n_perr - p0 !== 1 || cap_n - c0 !== 0) begin
      $display("FAIL parity_bad: got perr %0d writes %0d expected 1 0", n_perr - p0,
               cap_n - c0);
      errors++;
    end
    checks++;
    send_frame(8'h07, 1'b1);
    tick(Div);
    if (n_perr - p0 !== 1 || cap_n - c0 !== 1 || cap_mem[c0] !== 8'h07) begin
      $display("FAIL parity_good: got perr %0d writes %0d data %h expected 1 1 07",
               n_perr - p0, cap_n - c0, cap_mem[c0]);
      errors++;
    end
    checks++;
`else
    if (n_perr !== 0 || parity_err !== 1'b0) begin
      $display("FAIL parity_tied: got %0d pulses expected 0", n_perr); errors++;
    end
    checks++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_parity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
